// File: rtl/neuron_pkg.sv
// Shared types and helpers for the MAC neuron.
// Holds the FSM state enum, widths, cfg map and saturation.
package neuron_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int acc_width(
    input int n,
    input int xw,
    input int ww
  );
    return xw + ww + $clog2(n) + 2;
  endfunction

  function automatic int CFG_BIAS(input int n);
    return n;
  endfunction

  function automatic int CFG_THRESH(input int n);
    return n + 1;
  endfunction

  // Clamp a wide value into the signed w-bit range.
  function automatic logic signed [63:0] sat(
    input logic signed [63:0] v,
    input int                 w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic signed [63:0] sat_add(
    input logic signed [63:0] a,
    input logic signed [63:0] b,
    input int                 w
  );
    return sat(a + b, w);
  endfunction

endpackage

// File: rtl/neuron_mac.sv
// Signed weight times unsigned input, saturating add.
// Purely combinational; the top reuses it every cycle.
module neuron_mac
  import neuron_pkg::*;
#(
  parameter int XW   = 4,
  parameter int WW   = 4,
  parameter int ACCW = 12
) (
  input  logic signed [ACCW-1:0] i_acc,
  input  logic signed [WW-1:0]   i_w,
  input  logic        [XW-1:0]   i_x,
  output logic signed [ACCW-1:0] o_sum
);

  localparam int PW = WW + XW + 1;

  logic signed [PW-1:0] w_a;
  logic signed [PW-1:0] w_b;
  logic signed [PW-1:0] w_prod;

  assign w_a    = PW'(i_w);
  assign w_b    = PW'({1'b0, i_x});
  assign w_prod = w_a * w_b;
  assign o_sum  = ACCW'(sat_add(64'(i_acc),
                                64'(w_prod), ACCW));

endmodule

// File: rtl/mac_neuron_seq.sv
// N-input neuron, one time-multiplexed MAC, valid/ready I/O.
// Optional leaky membrane: define NEURON_LIF_EN.
module mac_neuron_seq
  import neuron_pkg::*;
#(
  parameter  int N          = 4,
  parameter  int XW         = 4,
  parameter  int WW         = 4,
  parameter  int LEAK_SHIFT = 1,
  localparam int ACCW       = acc_width(N, XW, WW),
  localparam int AW         = $clog2(N + 2)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N*XW-1:0]        x,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   y,
  output logic signed [ACCW-1:0] acc_out,
  input  logic                   cfg_we,
  input  logic [AW-1:0]          cfg_addr,
  input  logic [ACCW-1:0]        cfg_wdata,
  output logic                   cfg_busy
);

  localparam int IW = $clog2(N);
  localparam logic [AW-1:0] A_BIAS = AW'(CFG_BIAS(N));
  localparam logic [AW-1:0] A_THR  = AW'(CFG_THRESH(N));

  state_t                 r_state;
  logic        [XW-1:0]   r_x [N];
  logic signed [WW-1:0]   r_w [N];
  logic signed [ACCW-1:0] r_bias;
  logic signed [ACCW-1:0] r_thr;
  logic signed [ACCW-1:0] r_acc;
  logic signed [ACCW-1:0] r_acc_out;
  logic        [IW-1:0]   r_idx;
  logic                   r_y;
  logic                   r_out_valid;

  logic signed [ACCW-1:0] w_sum;
  logic signed [ACCW-1:0] w_acc0;
  logic                   w_idle;
  logic                   w_last;
  logic                   w_fire;

  assign w_idle    = (r_state == IDLE);
  assign w_last    = (r_idx == IW'(N - 1));
  assign w_fire    = (w_sum > r_thr);
  assign in_ready  = w_idle;
  assign cfg_busy  = !w_idle;
  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign acc_out   = r_acc_out;

`ifdef NEURON_LIF_EN
  logic signed [ACCW-1:0] r_mem;

  assign w_acc0 = ACCW'(sat_add(64'(r_bias),
                  64'(r_mem) - (64'(r_mem) >>> LEAK_SHIFT),
                  ACCW));

  // Membrane keeps the last sub-threshold sum, cleared on fire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem <= '0;
    end else if (r_state == ACCUM && w_last) begin
      r_mem <= w_fire ? '0 : w_sum;
    end
  end
`else
  assign w_acc0 = r_bias;
`endif

  neuron_mac #(
    .XW  (XW),
    .WW  (WW),
    .ACCW(ACCW)
  ) u_mac (
    .i_acc(r_acc),
    .i_w  (r_w[r_idx]),
    .i_x  (r_x[r_idx]),
    .o_sum(w_sum)
  );

  // Config registers, writable only while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) r_w[i] <= '0;
      r_bias <= '0;
      r_thr  <= '0;
    end else if (cfg_we && w_idle) begin
      unique case (1'b1)
        (cfg_addr < A_BIAS):
          r_w[cfg_addr[IW-1:0]] <= cfg_wdata[WW-1:0];
        (cfg_addr == A_BIAS):
          r_bias <= cfg_wdata;
        (cfg_addr == A_THR):
          r_thr <= cfg_wdata;
        default: ;
      endcase
    end
  end

  // Accept, N accumulate steps, then hold result until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      for (int i = 0; i < N; i++) r_x[i] <= '0;
      r_acc       <= '0;
      r_idx       <= '0;
      r_acc_out   <= '0;
      r_y         <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < N; i++)
              r_x[i] <= x[i*XW +: XW];
            r_acc   <= w_acc0;
            r_idx   <= '0;
            r_state <= ACCUM;
          end
        end
        ACCUM: begin
          r_acc <= w_sum;
          r_idx <= r_idx + IW'(1);
          if (w_last) begin
            r_acc_out   <= w_sum;
            r_y         <= w_fire;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_neuron_seq.sv
// Directed bench for mac_neuron_seq (N=4, XW=4, WW=4).
// Build with NEURON_LIF_EN to also exercise the membrane.
module tb_mac_neuron_seq;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [15:0]        x;
  logic               out_valid;
  logic               out_ready;
  logic               y;
  logic signed [11:0] acc_out;
  logic               cfg_we;
  logic [2:0]         cfg_addr;
  logic [11:0]        cfg_wdata;
  logic               cfg_busy;

  mac_neuron_seq #(
    .N(4), .XW(4), .WW(4), .LEAK_SHIFT(1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x        (x),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y        (y),
    .acc_out  (acc_out),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_wdata(cfg_wdata),
    .cfg_busy (cfg_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]        w;
    logic signed [11:0] bias;
    logic signed [11:0] thr;
    logic [15:0]        xv;
    int                 eacc;
    logic               ey;
  } vec_t;

  vec_t vec [7];
  int n_tests = 0;
  int n_fail  = 0;
  int lat;
  logic signed [11:0] racc;
  logic ry;
  logic rdy_bad, hold_bad, rel_bad;

  task automatic chk(input string nm, input int got,
                     input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, got, exp);
    end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic cfg_write(input logic [2:0] a,
                           input logic [11:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic apply_vec(input int i);
    logic [3:0] wn;
    reset_dut();
    for (int k = 0; k < 4; k++) begin
      wn = vec[i].w[k*4 +: 4];
      cfg_write(3'(k), {{8{wn[3]}}, wn});
    end
    cfg_write(3'd4, vec[i].bias);
    cfg_write(3'd5, vec[i].thr);
  endtask

  task automatic do_sample(input logic [15:0] xv,
                           input int hold);
    rdy_bad = 0; hold_bad = 0; rel_bad = 0;
    in_valid = 1'b1; x = xv;
    @(posedge clk); #1;
    in_valid = 1'b0; lat = 0;
    while (!out_valid && lat < 30) begin
      if (in_ready || !cfg_busy) rdy_bad = 1;
      @(posedge clk); #1;
      lat++;
    end
    if (in_ready) rdy_bad = 1;
    racc = acc_out; ry = y;
    repeat (hold) begin
      @(posedge clk); #1;
      if (!out_valid || acc_out != racc || y != ry || in_ready)
        hold_bad = 1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    if (out_valid || !in_ready) rel_bad = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0] = '{16'h3F12, 12'sd1, 12'sd6, 16'h0321, 2, 1'b0};
    vec[1] = '{16'h3F12, 12'sd1, 12'sd6, 16'h1033, 13, 1'b1};
    vec[2] = '{16'h7777, 12'h7FF, 12'sd0, 16'hFFFF, 2047, 1'b1};
    vec[3] = '{16'h8888, 12'h800, 12'sd0, 16'hFFFF, -2048, 1'b0};
    vec[4] = '{16'h0001, 12'sd0, 12'sd5, 16'h0005, 5, 1'b0};
    vec[5] = '{16'h0001, 12'sd0, 12'sd5, 16'h0006, 6, 1'b1};
    vec[6] = '{16'hFFFF, 12'sd0, -12'sd5, 16'h1111, -4, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; x = '0; out_ready = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    #2;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_y", int'(y), 0);
    chk("rst_acc_out", int'(acc_out), 0);
    chk("rst_cfg_busy", int'(cfg_busy), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      apply_vec(i);
      do_sample(vec[i].xv, 0);
      chk($sformatf("v%0d_acc", i), int'(acc_out), vec[i].eacc);
      chk($sformatf("v%0d_y", i), int'(y), int'(vec[i].ey));
      chk($sformatf("v%0d_lat", i), lat, 4);
      chk($sformatf("v%0d_busy", i), int'(rdy_bad), 0);
      chk($sformatf("v%0d_rel", i), int'(rel_bad), 0);
    end

    apply_vec(1);
    do_sample(16'h1033, 10);
    chk("hold_acc", int'(racc), 13);
    chk("hold_y", int'(ry), 1);
    chk("hold_stable", int'(hold_bad), 0);
    chk("hold_rel", int'(rel_bad), 0);

    apply_vec(0);
    in_valid = 1'b1; x = 16'h0321;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_wdata = 12'd5;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    lat = 0;
    while (!out_valid && lat < 30) begin
      @(posedge clk); #1; lat++;
    end
    chk("busy_wr_acc", int'(acc_out), 2);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    do_sample(16'h0001, 0);
    chk("busy_wr_w0", int'(acc_out), 3);

    apply_vec(0);
    cfg_write(3'd7, 12'd100);
    do_sample(16'h0321, 0);
    chk("addr7_acc", int'(acc_out), 2);
    chk("addr7_y", int'(y), 0);

    apply_vec(1);
    do_sample(16'h1033, 0);
    chk("pre_abort_acc", int'(acc_out), 13);
    in_valid = 1'b1; x = 16'h1033;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_y", int'(y), 0);
    chk("abort_acc_out", int'(acc_out), 0);
    chk("abort_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_sample(16'hFFFF, 0);
    chk("abort_cfg_acc", int'(acc_out), 0);
    chk("abort_cfg_y", int'(y), 0);

`ifdef NEURON_LIF_EN
    reset_dut();
    cfg_write(3'd0, 12'd1);
    cfg_write(3'd5, 12'd10);
    do_sample(16'h0008, 0);
    chk("lif1_acc", int'(acc_out), 8);
    chk("lif1_y", int'(y), 0);
    do_sample(16'h0008, 0);
    chk("lif2_acc", int'(acc_out), 12);
    chk("lif2_y", int'(y), 1);
    do_sample(16'h0008, 0);
    chk("lif3_acc", int'(acc_out), 8);
    chk("lif3_y", int'(y), 0);
`else
    apply_vec(0);
    do_sample(16'h0321, 0);
    do_sample(16'h0321, 0);
    chk("stateless_acc", int'(acc_out), 2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
